serial_adder: RTL and testbench

Parametrised bit-serial adder: adds two WIDTH-bit operands plus carry-in, one bit per clock, through a single full-adder cell with a registered carry. It is the multi-bit, clocked successor of the team's one-bit combinational adder. It serves area-constrained datapaths that can tolerate WIDTH cycles of latency, and uses a start/busy/done handshake toward the controlling logic.

---
 rtl/serial_adder_pkg.sv | 11 +
 rtl/serial_adder_if.sv | 20 ++
 rtl/serial_adder_defs.vh | 8 +
 rtl/serial_adder_full_adder.sv | 16 +
 rtl/serial_adder.sv | 110 +++++++++++
 tb/tb_serial_adder.sv | 222 ++++++++++++++++++++++
 6 files changed

// File: rtl/serial_adder_pkg.sv
// Purpose: shared constants and helpers for the bit-serial adder.
// Latency: n/a (package).
// Backpressure: n/a.
package serial_adder_pkg;
  `include "serial_adder_defs.vh"

  // Bit-counter width: enough bits to count WIDTH steps, never less than one.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction
endpackage

// File: rtl/serial_adder_if.sv
// Purpose: start/busy/done handshake and operand/result bus of the serial adder.
// Latency: n/a (wiring only).
// Backpressure: none; start is only honoured while the adder is idle.
// Ports: master = controlling logic (drives start/in1/in2/cin),
//        slave  = adder (drives busy/done/sum/cout).
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (output start, in1, in2, cin, input  busy, done, sum, cout);
  modport slave  (input  start, in1, in2, cin, output busy, done, sum, cout);
endinterface

// File: rtl/serial_adder_defs.vh
// Purpose: FSM state encoding shared by the serial adder RTL and its bench.
// Latency: n/a (constants only).
// Backpressure: n/a.
`ifndef SERIAL_ADDER_DEFS_VH
`define SERIAL_ADDER_DEFS_VH
localparam logic [0:0] IDLE = 1'b0;
localparam logic [0:0] RUN  = 1'b1;
`endif

// File: rtl/serial_adder_full_adder.sv
// Purpose: one-bit combinational full adder (the serial adder's only arithmetic cell).
// Latency: 0 cycles, purely combinational.
// Backpressure: n/a.
// Ports: a, b, ci in; s = a^b^ci, co = majority(a,b,ci) out.
module full_adder
  import serial_adder_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);
endmodule

// File: rtl/serial_adder.sv
// Purpose: WIDTH-bit unsigned adder processing one bit per clock through a single full adder.
// Latency: done pulses WIDTH edges after the accepting edge; busy high in between.
// Backpressure: start ignored while busy; next accept possible on the edge after done.
// Ports: sys_clk, sys_rst_n (async, active low); bus = slave side of serial_adder_if.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  serial_adder_if.slave bus
);
  localparam int              CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] p_sr_q, p_sr_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             done_q, done_d;

  logic             fa_s;
  logic             fa_co;
  logic [WIDTH-1:0] p_next;

  full_adder u_fa (
    .a  (a_sr_q[0]),
    .b  (b_sr_q[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  // LSB is added first, so each new sum bit enters at the MSB; after WIDTH
  // shifts bit 0 of the result has reached position 0.
  always_comb begin
    p_next            = p_sr_q >> 1;
    p_next[WIDTH-1]   = fa_s;
  end

  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    p_sr_d  = p_sr_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    done_d  = 1'b0;

    if (state_q == IDLE) begin
      if (bus.start) begin
        a_sr_d  = bus.in1;
        b_sr_d  = bus.in2;
        carry_d = bus.cin;
        cnt_d   = '0;
        p_sr_d  = '0;
        state_d = RUN;
      end
    end else begin
      a_sr_d  = a_sr_q >> 1;
      b_sr_d  = b_sr_q >> 1;
      p_sr_d  = p_next;
      carry_d = fa_co;
      cnt_d   = cnt_q + CNT_W'(1);
      if (cnt_q == LAST) begin
        // Result is taken from p_next so the bit added this cycle is included.
        sum_d   = p_next;
        cout_d  = fa_co;
        done_d  = 1'b1;
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      p_sr_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      p_sr_q  <= p_sr_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = (state_q == RUN);
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
endmodule

// File: tb/tb_serial_adder.sv
// Purpose: randomized + directed scoreboard bench for serial_adder (WIDTH=8 and WIDTH=1).
// Latency: model expects done WIDTH edges after each accepted start.
// Backpressure: model ignores start while an addition is outstanding.
module tb_serial_adder;
  import serial_adder_pkg::*;

  logic clk;
  logic rst_n;

  serial_adder_if #(.WIDTH(8)) bus8 ();
  serial_adder_if #(.WIDTH(1)) bus1 ();

  serial_adder #(.WIDTH(8)) u_dut8 (.sys_clk(clk), .sys_rst_n(rst_n), .bus(bus8));
  serial_adder #(.WIDTH(1)) u_dut1 (.sys_clk(clk), .sys_rst_n(rst_n), .bus(bus1));

  typedef struct {
    logic [8:0] res;
    int         cyc;
  } exp_t;

  exp_t       q[$];
  int         tests;
  int         fails;
  int         cyc;
  int         free_at;
  logic [7:0] held_sum;
  logic       held_cout;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: an accepted start yields {cout,sum} = in1+in2+cin after
  // exactly WIDTH edges; the adder is unavailable until the edge after that.
  initial begin
    exp_t e;
    cyc     = 0;
    free_at = 0;
    forever begin
      @(posedge clk);
      cyc++;
      if (rst_n && bus8.start && cyc >= free_at) begin
        e.res   = {1'b0, bus8.in1} + {1'b0, bus8.in2} + {8'd0, bus8.cin};
        e.cyc   = cyc + 8;
        q.push_back(e);
        free_at = cyc + 9;
      end
    end
  end

  // Monitor: compares outputs of the WIDTH=8 instance every cycle.
  initial begin
    exp_t e;
    logic busy_exp;
    forever begin
      @(negedge clk);
      busy_exp = (q.size() > 0) && (q[0].cyc != cyc);
      check("busy", bus8.busy, busy_exp);
      if (bus8.done) begin
        if (q.size() == 0) begin
          check("spurious_done", 1, 0);
        end else begin
          e = q.pop_front();
          check("done_cycle", cyc, e.cyc);
          check("sum", bus8.sum, e.res[7:0]);
          check("cout", bus8.cout, e.res[8]);
          held_sum  = e.res[7:0];
          held_cout = e.res[8];
        end
      end else begin
        if (q.size() > 0 && cyc >= q[0].cyc) begin
          check("missing_done", 0, 1);
          void'(q.pop_front());
        end
        check("held_sum", bus8.sum, held_sum);
        check("held_cout", bus8.cout, held_cout);
      end
    end
  end

  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic c);
    @(negedge clk);
    bus8.start = 1'b1;
    bus8.in1   = a;
    bus8.in2   = b;
    bus8.cin   = c;
    @(negedge clk);
    bus8.start = 1'b0;
    bus8.in1   = 8'($urandom);
    bus8.in2   = 8'($urandom);
    bus8.cin   = 1'($urandom);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      check("idle_timeout", 0, 1);
      q.delete();
    end
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    #2;
    rst_n     = 1'b0;
    q.delete();
    free_at   = 0;
    held_sum  = 8'h00;
    held_cout = 1'b0;
    #1;
    check("rst_busy", bus8.busy, 0);
    check("rst_done", bus8.done, 0);
    check("rst_sum", bus8.sum, 0);
    check("rst_cout", bus8.cout, 0);
    repeat (n) @(negedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    tests      = 0;
    fails      = 0;
    held_sum   = 8'h00;
    held_cout  = 1'b0;
    rst_n      = 1'b0;
    bus8.start = 1'b1;
    bus8.in1   = 8'hFF;
    bus8.in2   = 8'hFF;
    bus8.cin   = 1'b1;
    bus1.start = 1'b0;
    bus1.in1   = 1'b0;
    bus1.in2   = 1'b0;
    bus1.cin   = 1'b0;

    // Reset held for 5 cycles with start high: nothing may happen.
    #1;
    check("init_busy", bus8.busy, 0);
    check("init_done", bus8.done, 0);
    check("init_sum", bus8.sum, 0);
    check("init_cout", bus8.cout, 0);
    check("init_w1_busy", bus1.busy, 0);
    check("init_w1_sum", bus1.sum, 0);
    repeat (5) @(negedge clk);
    #2;
    bus8.start = 1'b0;
    rst_n      = 1'b1;

    issue(8'h5A, 8'h3C, 1'b0);
    wait_idle();

    // Carry chains; the second run must hold the first result until it completes.
    issue(8'hFF, 8'h01, 1'b0);
    wait_idle();
    issue(8'hFF, 8'hFF, 1'b1);
    wait_idle();

    // A start during RUN is ignored.
    issue(8'h10, 8'h20, 1'b0);
    repeat (2) @(negedge clk);
    issue(8'hFF, 8'hFF, 1'b1);
    wait_idle();

    // start held continuously: back-to-back accepts every WIDTH+1 cycles.
    @(negedge clk);
    bus8.start = 1'b1;
    bus8.in1   = 8'h01;
    bus8.in2   = 8'h02;
    bus8.cin   = 1'b0;
    repeat (30) @(negedge clk);
    bus8.start = 1'b0;
    wait_idle();

    // Reset in the middle of a run aborts it without a done pulse.
    issue(8'h77, 8'h66, 1'b1);
    repeat (3) @(negedge clk);
    do_reset(2);
    issue(8'h80, 8'h80, 1'b0);
    wait_idle();

    // WIDTH=1: done one edge after the accepting edge.
    @(negedge clk);
    bus1.start = 1'b1;
    bus1.in1   = 1'b1;
    bus1.in2   = 1'b1;
    bus1.cin   = 1'b1;
    @(negedge clk);
    bus1.start = 1'b0;
    bus1.in1   = 1'b0;
    bus1.in2   = 1'b0;
    bus1.cin   = 1'b0;
    check("w1_busy_run", bus1.busy, 1);
    check("w1_done_early", bus1.done, 0);
    @(negedge clk);
    check("w1_done", bus1.done, 1);
    check("w1_sum", bus1.sum, 1);
    check("w1_cout", bus1.cout, 1);
    check("w1_busy_done", bus1.busy, 0);
    @(negedge clk);
    check("w1_done_pulse", bus1.done, 0);
    check("w1_sum_held", bus1.sum, 1);

    // Random operands with random gaps; some starts land while busy.
    for (int i = 0; i < 40; i++) begin
      issue(8'($urandom), 8'($urandom), 1'($urandom));
      repeat ($urandom_range(0, 12)) @(negedge clk);
    end
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
